// File: rtl/bus_arbiter.sv
// Two-port arbiter sharing one memory bus between instruction fetch and the MEM stage.
// Data requests win ties; every transaction is bounded by a WAIT_MAX-cycle timeout.
module bus_arbiter #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_sel,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        bus_ce,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        stallreq,
  output logic        timeout_o
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LIMIT);
  assign stallreq     = (if_req & ~if_ack) | (dm_req & ~dm_ack);

  // A port whose ack is currently high is skipped in IDLE so a request that has
  // not yet been dropped cannot be granted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_rdata  <= '0;
      dm_ack    <= 1'b0;
      bus_ce    <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      timeout_o <= 1'b0;
    end else begin
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req && !dm_ack) begin
            state     <= DM_BUSY;
            wait_cnt  <= '0;
            bus_ce    <= 1'b1;
            bus_we    <= dm_we;
            bus_sel   <= dm_sel;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
          end else if (if_req && !if_ack) begin
            state     <= IF_BUSY;
            wait_cnt  <= '0;
            bus_ce    <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'b1111;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
          end
        end
        IF_BUSY: begin
          if (bus_ready || wait_expired) begin
            if_ack    <= 1'b1;
            if_rdata  <= bus_ready ? bus_rdata : 32'h0;
            timeout_o <= ~bus_ready;
            bus_ce    <= 1'b0;
            bus_we    <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DM_BUSY: begin
          // bus_we is held for the whole transaction, so it tells reads from writes.
          if (bus_ready || wait_expired) begin
            dm_ack    <= 1'b1;
            if (!bus_we) dm_rdata <= bus_ready ? bus_rdata : 32'h0;
            timeout_o <= ~bus_ready;
            bus_ce    <= 1'b0;
            bus_we    <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected completions are queued when a request
// is driven and compared when the matching ack appears.
module tb_bus_arbiter;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_sel = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        bus_ce;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        stallreq;
  logic        timeout_o;

  typedef struct {
    logic        is_dm;
    logic [31:0] rdata;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          lat;
  logic [31:0] last_dm_rdata = '0;
  logic        first_we;
  logic [3:0]  first_sel;
  logic [31:0] first_addr;
  logic [31:0] first_wdata;
  int          addr_changes;

  bus_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .bus_ce(bus_ce), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .stallreq(stallreq), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected completion: ready after `delay` low cycles, or timeout once the
  // counter has sat at WAIT_MAX for a cycle without ready.
  function automatic exp_t model(input logic is_dm, input int delay, input logic [31:0] rd,
                                 input logic is_write, input logic [31:0] prev);
    exp_t r;
    r.is_dm = is_dm;
    r.tmo   = (delay > WAIT_MAX);
    r.lat   = r.tmo ? WAIT_MAX + 2 : delay + 2;
    r.rdata = is_write ? prev : (r.tmo ? 32'h0 : rd);
    return r;
  endfunction

  // Memory responder: holds ready low for `delay` busy cycles, then raises it.
  task automatic run_until_ack(input int delay, input logic [31:0] rd, output int cycles);
    int busy = 0;
    cycles = 0;
    addr_changes = 0;
    do begin
      bus_ready = bus_ce && (busy >= delay);
      if (bus_ce) busy++;
      bus_rdata = rd;
      step();
      cycles++;
      if (bus_ce && busy == 0) begin
        first_we = bus_we; first_sel = bus_sel;
        first_addr = bus_addr; first_wdata = bus_wdata;
      end else if (bus_ce && bus_addr !== first_addr) begin
        addr_changes++;
      end
    end while (!(if_ack || dm_ack) && cycles < 40);
    bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h55;
    step(); step();
    n_checks++;
    if ({bus_ce, bus_we, bus_sel, bus_addr, bus_wdata, if_ack, dm_ack, if_rdata, dm_rdata, timeout_o} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: ce=%b addr=%h if_rdata=%h dm_rdata=%h want all zero", bus_ce, bus_addr, if_rdata, dm_rdata);
    end
    n_checks++;
    if (stallreq !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_stallreq: got %b want 1", stallreq); end
    if_req = 1'b0; dm_req = 1'b0; rst = 1'b0;
    step();
    n_checks++;
    if (stallreq !== 1'b0 || bus_ce !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_after_reset: stall=%b ce=%b want 0 0", stallreq, bus_ce); end
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h4;
    sb.push_back(model(1'b0, 0, 32'h34011100, 1'b0, 32'h0));
    run_until_ack(0, 32'h34011100, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || if_ack !== 1'b1 || dm_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_ack: lat=%0d if_ack=%b dm_ack=%b want lat=%0d if_ack=1", lat, if_ack, dm_ack, e.lat); end
    n_checks++;
    if (if_rdata !== e.rdata || timeout_o !== e.tmo) begin n_fail++; $display("[TB] FAIL fetch_data: rdata=%h tmo=%b want %h %b", if_rdata, timeout_o, e.rdata, e.tmo); end
    n_checks++;
    if (first_addr !== 32'h4 || first_we !== 1'b0 || first_sel !== 4'b1111) begin n_fail++; $display("[TB] FAIL fetch_bus: addr=%h we=%b sel=%b want 4 0 1111", first_addr, first_we, first_sel); end
    if_req = 1'b0;
    step();
    n_checks++;
    if (if_ack !== 1'b0 || bus_ce !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_pulse: if_ack=%b ce=%b want 0 0", if_ack, bus_ce); end
  endtask

  task automatic test_wait_states();
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'b1111; dm_addr = 32'h200;
    sb.push_back(model(1'b1, 3, 32'h12345678, 1'b0, last_dm_rdata));
    run_until_ack(3, 32'h12345678, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || dm_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL wait_latency: lat=%0d dm_ack=%b want %0d 1", lat, dm_ack, e.lat); end
    n_checks++;
    if (dm_rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL wait_rdata: got %h want %h", dm_rdata, e.rdata); end
    n_checks++;
    if (addr_changes !== 0 || first_addr !== 32'h200) begin n_fail++; $display("[TB] FAIL wait_addr_stable: changes=%0d addr=%h want 0 200", addr_changes, first_addr); end
    last_dm_rdata = e.rdata;
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h8;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_sel = 4'b1111;
    sb.push_back(model(1'b1, 0, 32'hCAFEF00D, 1'b1, last_dm_rdata));
    sb.push_back(model(1'b0, 0, 32'h00000013, 1'b0, 32'h0));
    run_until_ack(0, 32'hCAFEF00D, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || dm_ack !== 1'b1 || if_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_dm_first: lat=%0d dm_ack=%b if_ack=%b want %0d 1 0", lat, dm_ack, if_ack, e.lat); end
    n_checks++;
    if (first_we !== 1'b1 || first_addr !== 32'h100 || first_wdata !== 32'hDEADBEEF || first_sel !== 4'b1111) begin
      n_fail++; $display("[TB] FAIL prio_dm_bus: we=%b addr=%h wdata=%h sel=%b want 1 100 deadbeef 1111", first_we, first_addr, first_wdata, first_sel);
    end
    n_checks++;
    if (dm_rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL write_holds_rdata: got %h want %h", dm_rdata, e.rdata); end
    n_checks++;
    if (stallreq !== 1'b1 || bus_ce !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_turnaround: stall=%b ce=%b want 1 0", stallreq, bus_ce); end
    dm_req = 1'b0; dm_we = 1'b0;
    run_until_ack(0, 32'h00000013, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || if_ack !== 1'b1 || if_rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL prio_fetch: lat=%0d ack=%b rdata=%h want %0d 1 %h", lat, if_ack, if_rdata, e.lat, e.rdata); end
    n_checks++;
    if (first_addr !== 32'h8 || first_we !== 1'b0 || stallreq !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_fetch_bus: addr=%h we=%b stall=%b want 8 0 0", first_addr, first_we, stallreq); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 32'h40;
    sb.push_back(model(1'b0, 1000, 32'hFFFFFFFF, 1'b0, 32'h0));
    run_until_ack(1000, 32'hFFFFFFFF, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || if_ack !== 1'b1 || timeout_o !== e.tmo) begin n_fail++; $display("[TB] FAIL timeout_pulse: lat=%0d ack=%b tmo=%b want %0d 1 %b", lat, if_ack, timeout_o, e.lat, e.tmo); end
    n_checks++;
    if (if_rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL timeout_rdata: got %h want %h", if_rdata, e.rdata); end
    if_req = 1'b0;
    step();
    n_checks++;
    if (timeout_o !== 1'b0 || if_ack !== 1'b0 || bus_ce !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_idle: tmo=%b ack=%b ce=%b want 0 0 0", timeout_o, if_ack, bus_ce); end
  endtask

  task automatic test_ready_at_limit();
    if_req = 1'b1; if_addr = 32'h44;
    sb.push_back(model(1'b0, WAIT_MAX, 32'hA5A50F0F, 1'b0, 32'h0));
    run_until_ack(WAIT_MAX, 32'hA5A50F0F, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || timeout_o !== e.tmo || if_rdata !== e.rdata) begin
      n_fail++; $display("[TB] FAIL ready_at_limit: lat=%0d tmo=%b rdata=%h want %0d %b %h", lat, timeout_o, if_rdata, e.lat, e.tmo, e.rdata);
    end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_op();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h280; bus_ready = 1'b0;
    step(); step(); step();
    n_checks++;
    if (bus_ce !== 1'b1 || bus_addr !== 32'h280) begin n_fail++; $display("[TB] FAIL midop_busy: ce=%b addr=%h want 1 280", bus_ce, bus_addr); end
    rst = 1'b1;
    step();
    n_checks++;
    if ({bus_ce, bus_we, bus_sel, bus_addr, bus_wdata, if_ack, dm_ack, if_rdata, dm_rdata, timeout_o} !== '0 || stallreq !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midop_reset: ce=%b addr=%h dm_ack=%b dm_rdata=%h stall=%b want zeros, stall 1", bus_ce, bus_addr, dm_ack, dm_rdata, stallreq);
    end
    rst = 1'b0;
    sb.push_back(model(1'b1, 0, 32'h0BADF00D, 1'b0, 32'h0));
    run_until_ack(0, 32'h0BADF00D, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || dm_ack !== 1'b1 || dm_rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL midop_recover: lat=%0d ack=%b rdata=%h want %0d 1 %h", lat, dm_ack, dm_rdata, e.lat, e.rdata); end
    last_dm_rdata = e.rdata;
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    sb.push_back(model(1'b1, 0, 32'h11112222, 1'b0, last_dm_rdata));
    run_until_ack(0, 32'h11112222, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || dm_rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL b2b_first: lat=%0d rdata=%h want %0d %h", lat, dm_rdata, e.lat, e.rdata); end
    step();
    n_checks++;
    if (bus_ce !== 1'b0 || dm_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_turnaround: ce=%b ack=%b want 0 0", bus_ce, dm_ack); end
    dm_addr = 32'h304;
    sb.push_back(model(1'b1, 1, 32'h33334444, 1'b0, 32'h0));
    run_until_ack(1, 32'h33334444, lat);
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat || dm_rdata !== e.rdata || first_addr !== 32'h304) begin
      n_fail++; $display("[TB] FAIL b2b_second: lat=%0d rdata=%h addr=%h want %0d %h 304", lat, dm_rdata, first_addr, e.lat, e.rdata);
    end
    dm_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_wait_states();
    test_priority();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
